// File: rtl/decode_hazard_ctrl_if.sv
// Decode-to-register-fetch handshake, scoreboard writeback and flush signals.
// master drives decode/rfetch-ready/writeback/flush; slave is the hazard controller.
interface decode_hazard_ctrl_if #(
  parameter int unsigned REG_W = 5
);
  logic             dec_v;
  logic [REG_W-1:0] dec_rs1;
  logic             dec_rs1_v;
  logic [REG_W-1:0] dec_rs2;
  logic             dec_rs2_v;
  logic [REG_W-1:0] dec_rd;
  logic             dec_rd_w_v;
  logic             dec_ready;
  logic             issue_v;
  logic             rf_ready;
  logic             wb_v;
  logic [REG_W-1:0] wb_rd;
  logic             flush;

  modport master (
    output dec_v, dec_rs1, dec_rs1_v, dec_rs2, dec_rs2_v, dec_rd, dec_rd_w_v,
    output rf_ready, wb_v, wb_rd, flush,
    input  dec_ready, issue_v
  );

  modport slave (
    input  dec_v, dec_rs1, dec_rs1_v, dec_rs2, dec_rs2_v, dec_rd, dec_rd_w_v,
    input  rf_ready, wb_v, wb_rd, flush,
    output dec_ready, issue_v
  );
endinterface

// File: rtl/decode_hazard_ctrl.sv
// Decode/rfetch issue scheduler with a per-register in-flight write scoreboard.
// Optional RVGA_HAZ_BYPASS_EN: a same-cycle retiring last write clears the read hazard.
module decode_hazard_ctrl #(
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned REG_W        = 5,
  parameter int unsigned MAX_INFLIGHT = 3,
  parameter int unsigned STALL_CNT_W  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  decode_hazard_ctrl_if.slave    bus,
  output logic [1:0]             state_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o,
  output logic                   sb_err_o
);

  localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StStall = 2'd1,
    StDrain = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q [NUM_REGS];
  logic [CW-1:0]          cnt_d [NUM_REGS];
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   sb_err_q, sb_err_d;

  logic [NUM_REGS-1:0] pend;
  logic                hazard;
  logic                issue_v;
  logic                fire;
  logic                all_idle;

  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      pend[r] = (r != 0) && (cnt_q[r] != '0);
`ifdef RVGA_HAZ_BYPASS_EN
      if (bus.wb_v && (bus.wb_rd == REG_W'(r)) && (cnt_q[r] == CW'(1))) begin
        pend[r] = 1'b0;
      end
`endif
    end
  end

  always_comb begin
    hazard = (bus.dec_rs1_v && pend[bus.dec_rs1]) ||
             (bus.dec_rs2_v && pend[bus.dec_rs2]) ||
             (bus.dec_rd_w_v && (cnt_q[bus.dec_rd] == CW'(MAX_INFLIGHT)));
    // Reset gates the handshake combinationally so nothing leaks out while held.
    issue_v = rst_ni && bus.dec_v && !hazard && !bus.flush && (state_q != StDrain);
    fire    = issue_v && bus.rf_ready;
  end

  assign bus.issue_v   = issue_v;
  assign bus.dec_ready = fire;

  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      logic inc, dec;
      cnt_d[r] = cnt_q[r];
      inc = fire && bus.dec_rd_w_v && (bus.dec_rd == REG_W'(r));
      dec = bus.wb_v && (bus.wb_rd == REG_W'(r)) && (cnt_q[r] != '0);
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (inc && !dec) begin
        cnt_d[r] = cnt_q[r] + CW'(1);
      end else if (dec && !inc) begin
        cnt_d[r] = cnt_q[r] - CW'(1);
      end
    end
  end

  always_comb begin
    all_idle = 1'b1;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if (cnt_q[r] != '0) all_idle = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = StDrain;
    end else begin
      case (state_q)
        StDrain: state_d = all_idle ? StRun : StDrain;
        StRun, StStall: state_d = (bus.dec_v && hazard) ? StStall : StRun;
        default: state_d = StRun;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if ((state_q == StStall) && (stall_q != '1)) begin
      stall_d = stall_q + STALL_CNT_W'(1);
    end
    sb_err_d = sb_err_q || (bus.wb_v && (cnt_q[bus.wb_rd] == '0));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StRun;
      stall_q  <= '0;
      sb_err_q <= 1'b0;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      state_q  <= state_d;
      stall_q  <= stall_d;
      sb_err_q <= sb_err_d;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  assign state_o     = state_q;
  assign stall_cnt_o = stall_q;
  assign sb_err_o    = sb_err_q;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Directed bench for decode_hazard_ctrl; expectations follow RVGA_HAZ_BYPASS_EN when set.
module tb_decode_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic        sb_err;
  int          passed;
  int          total;
  int          exp_stall;

  decode_hazard_ctrl_if #(.REG_W(5)) bus ();

  decode_hazard_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (bus),
    .state_o     (state),
    .stall_cnt_o (stall_cnt),
    .sb_err_o    (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dec_v      = 1'b0;
    bus.dec_rs1    = '0;
    bus.dec_rs1_v  = 1'b0;
    bus.dec_rs2    = '0;
    bus.dec_rs2_v  = 1'b0;
    bus.dec_rd     = '0;
    bus.dec_rd_w_v = 1'b0;
    bus.rf_ready   = 1'b0;
    bus.wb_v       = 1'b0;
    bus.wb_rd      = '0;
    bus.flush      = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    bus.dec_v    = 1'b1;
    bus.rf_ready = 1'b1;
    #2;
    total++; if (bus.issue_v !== 1'b0) $display("FAIL rst_issue_v got %b want 0", bus.issue_v); else passed++;
    total++; if (bus.dec_ready !== 1'b0) $display("FAIL rst_dec_ready got %b want 0", bus.dec_ready); else passed++;
    total++; if (state !== 2'd0) $display("FAIL rst_state got %0d want 0", state); else passed++;
    total++; if (stall_cnt !== 16'd0) $display("FAIL rst_stall_cnt got %0d want 0", stall_cnt); else passed++;
    total++; if (sb_err !== 1'b0) $display("FAIL rst_sb_err got %b want 0", sb_err); else passed++;
    tick();
    rst_n = 1'b1;
    idle();
    tick();
  endtask

  task automatic test_raw();
    idle();
    bus.dec_v = 1'b1; bus.dec_rd = 5'd3; bus.dec_rd_w_v = 1'b1; bus.rf_ready = 1'b1;
    #1;
    total++; if (bus.dec_ready !== 1'b1) $display("FAIL raw_producer dec_ready got %b want 1", bus.dec_ready); else passed++;
    tick();
    bus.dec_rd_w_v = 1'b0; bus.dec_rs1 = 5'd3; bus.dec_rs1_v = 1'b1;
    #1;
    total++; if (bus.issue_v !== 1'b0) $display("FAIL raw_hazard issue_v got %b want 0", bus.issue_v); else passed++;
    tick();
    total++; if (state !== 2'd1) $display("FAIL raw_stall_state got %0d want 1", state); else passed++;
    bus.wb_v = 1'b1; bus.wb_rd = 5'd3;
    #1;
`ifdef RVGA_HAZ_BYPASS_EN
    total++; if (bus.dec_ready !== 1'b1) $display("FAIL raw_bypass dec_ready got %b want 1", bus.dec_ready); else passed++;
    tick();
    bus.wb_v = 1'b0; bus.dec_v = 1'b0;
    exp_stall = 1;
`else
    total++; if (bus.issue_v !== 1'b0) $display("FAIL raw_wb_cycle issue_v got %b want 0", bus.issue_v); else passed++;
    tick();
    bus.wb_v = 1'b0;
    #1;
    total++; if (bus.dec_ready !== 1'b1) $display("FAIL raw_release dec_ready got %b want 1", bus.dec_ready); else passed++;
    total++; if (state !== 2'd1) $display("FAIL raw_release_state got %0d want 1", state); else passed++;
    tick();
    bus.dec_v = 1'b0;
    exp_stall = 2;
`endif
    total++; if (state !== 2'd0) $display("FAIL raw_back_to_run got %0d want 0", state); else passed++;
    total++; if (stall_cnt !== 16'(exp_stall)) $display("FAIL raw_stall_cnt got %0d want %0d", stall_cnt, exp_stall); else passed++;
    idle();
  endtask

  task automatic test_saturation();
    idle();
    bus.dec_v = 1'b1; bus.dec_rd = 5'd7; bus.dec_rd_w_v = 1'b1; bus.rf_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (bus.dec_ready !== 1'b1) $display("FAIL sat_fill%0d dec_ready got %b want 1", i, bus.dec_ready); else passed++;
      tick();
    end
    #1;
    total++; if (bus.dec_ready !== 1'b0) $display("FAIL sat_full dec_ready got %b want 0", bus.dec_ready); else passed++;
    tick();
    total++; if (state !== 2'd1) $display("FAIL sat_stall_state got %0d want 1", state); else passed++;
    bus.wb_v = 1'b1; bus.wb_rd = 5'd7;
    #1;
    total++; if (bus.dec_ready !== 1'b0) $display("FAIL sat_wb_cycle dec_ready got %b want 0", bus.dec_ready); else passed++;
    tick();
    bus.wb_v = 1'b0;
    #1;
    total++; if (bus.dec_ready !== 1'b1) $display("FAIL sat_release dec_ready got %b want 1", bus.dec_ready); else passed++;
    tick();
    bus.dec_v = 1'b0; bus.dec_rd_w_v = 1'b0;
    exp_stall += 2;
    total++; if (stall_cnt !== 16'(exp_stall)) $display("FAIL sat_stall_cnt got %0d want %0d", stall_cnt, exp_stall); else passed++;
    bus.wb_v = 1'b1; bus.wb_rd = 5'd7;
    for (int i = 0; i < 3; i++) tick();
    bus.wb_v = 1'b0;
    total++; if (sb_err !== 1'b0) $display("FAIL sat_drain_sb_err got %b want 0", sb_err); else passed++;
    idle();
  endtask

  task automatic test_flush();
    idle();
    bus.dec_v = 1'b1; bus.dec_rd_w_v = 1'b1; bus.rf_ready = 1'b1; bus.dec_rd = 5'd10;
    tick();
    bus.dec_rd = 5'd11;
    tick();
    bus.dec_rd = 5'd12; bus.rf_ready = 1'b0; bus.flush = 1'b1;
    #1;
    total++; if (bus.issue_v !== 1'b0) $display("FAIL flush_cycle issue_v got %b want 0", bus.issue_v); else passed++;
    tick();
    bus.flush = 1'b0;
    #1;
    total++; if (state !== 2'd2) $display("FAIL drain_enter state got %0d want 2", state); else passed++;
    total++; if (bus.issue_v !== 1'b0) $display("FAIL drain_hold issue_v got %b want 0", bus.issue_v); else passed++;
    bus.flush = 1'b1; bus.wb_v = 1'b1; bus.wb_rd = 5'd10;
    tick();
    bus.flush = 1'b0;
    total++; if (state !== 2'd2) $display("FAIL drain_reflush state got %0d want 2", state); else passed++;
    bus.wb_rd = 5'd11;
    #1;
    total++; if (bus.issue_v !== 1'b0) $display("FAIL drain_wb issue_v got %b want 0", bus.issue_v); else passed++;
    tick();
    bus.wb_v = 1'b0;
    #1;
    total++; if (state !== 2'd2) $display("FAIL drain_last state got %0d want 2", state); else passed++;
    total++; if (bus.issue_v !== 1'b0) $display("FAIL drain_last issue_v got %b want 0", bus.issue_v); else passed++;
    tick();
    total++; if (state !== 2'd0) $display("FAIL drain_exit state got %0d want 0", state); else passed++;
    #1;
    total++; if (bus.issue_v !== 1'b1) $display("FAIL drain_exit issue_v got %b want 1", bus.issue_v); else passed++;
    idle();
    tick();
  endtask

  task automatic test_simul_wb();
    idle();
    bus.dec_v = 1'b1; bus.dec_rd_w_v = 1'b1; bus.dec_rd = 5'd9; bus.rf_ready = 1'b1;
    tick();
    bus.wb_v = 1'b1; bus.wb_rd = 5'd9;
    #1;
    total++; if (bus.dec_ready !== 1'b1) $display("FAIL simul_fire dec_ready got %b want 1", bus.dec_ready); else passed++;
    tick();
    bus.wb_v = 1'b0; bus.dec_rd_w_v = 1'b0; bus.dec_rs1 = 5'd9; bus.dec_rs1_v = 1'b1;
    bus.rf_ready = 1'b0;
    #1;
    total++; if (bus.issue_v !== 1'b0) $display("FAIL simul_pending issue_v got %b want 0", bus.issue_v); else passed++;
    bus.dec_v = 1'b0; bus.wb_v = 1'b1; bus.wb_rd = 5'd9;
    tick();
    bus.wb_v = 1'b0;
    total++; if (sb_err !== 1'b0) $display("FAIL simul_no_err sb_err got %b want 0", sb_err); else passed++;
    bus.dec_v = 1'b1;
    #1;
    total++; if (bus.issue_v !== 1'b1) $display("FAIL simul_cleared issue_v got %b want 1", bus.issue_v); else passed++;
    idle();
    bus.wb_v = 1'b1; bus.wb_rd = 5'd4;
    tick();
    bus.wb_v = 1'b0;
    total++; if (sb_err !== 1'b1) $display("FAIL sb_err_set got %b want 1", sb_err); else passed++;
    tick();
    tick();
    total++; if (sb_err !== 1'b1) $display("FAIL sb_err_sticky got %b want 1", sb_err); else passed++;
  endtask

  task automatic test_x0();
    idle();
    bus.dec_v = 1'b1; bus.dec_rs1_v = 1'b1; bus.dec_rs2_v = 1'b1;
    bus.dec_rd_w_v = 1'b1; bus.rf_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (bus.dec_ready !== 1'b1) $display("FAIL x0_issue%0d dec_ready got %b want 1", i, bus.dec_ready); else passed++;
      tick();
    end
    total++; if (state !== 2'd0) $display("FAIL x0_state got %0d want 0", state); else passed++;
    bus.rf_ready = 1'b0;
    #1;
    total++; if (bus.issue_v !== 1'b1) $display("FAIL x0_rf_stall issue_v got %b want 1", bus.issue_v); else passed++;
    total++; if (bus.dec_ready !== 1'b0) $display("FAIL x0_rf_stall dec_ready got %b want 0", bus.dec_ready); else passed++;
    tick();
    total++; if (stall_cnt !== 16'(exp_stall)) $display("FAIL x0_stall_cnt got %0d want %0d", stall_cnt, exp_stall); else passed++;
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    bus.dec_v = 1'b1; bus.dec_rd_w_v = 1'b1; bus.dec_rd = 5'd5; bus.rf_ready = 1'b1;
    tick();
    tick();
    bus.dec_rd_w_v = 1'b0; bus.dec_rs1 = 5'd5; bus.dec_rs1_v = 1'b1;
    #1;
    total++; if (bus.issue_v !== 1'b0) $display("FAIL mid_hazard issue_v got %b want 0", bus.issue_v); else passed++;
    tick();
    total++; if (state !== 2'd1) $display("FAIL mid_stall state got %0d want 1", state); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (state !== 2'd0) $display("FAIL mid_rst_state got %0d want 0", state); else passed++;
    total++; if (bus.issue_v !== 1'b0) $display("FAIL mid_rst_issue_v got %b want 0", bus.issue_v); else passed++;
    total++; if (bus.dec_ready !== 1'b0) $display("FAIL mid_rst_dec_ready got %b want 0", bus.dec_ready); else passed++;
    total++; if (stall_cnt !== 16'd0) $display("FAIL mid_rst_stall_cnt got %0d want 0", stall_cnt); else passed++;
    total++; if (sb_err !== 1'b0) $display("FAIL mid_rst_sb_err got %b want 0", sb_err); else passed++;
    tick();
    rst_n = 1'b1;
    #1;
    total++; if (bus.issue_v !== 1'b1) $display("FAIL mid_cnt_cleared issue_v got %b want 1", bus.issue_v); else passed++;
    tick();
    idle();
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    exp_stall = 0;
    test_reset();
    test_raw();
    test_saturation();
    test_flush();
    test_simul_wb();
    test_x0();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
